// File: rtl/fpt_telemetry_sched_pkg.sv
// Shared constants, frame layout and state encoding for the telemetry scheduler.
// FRAME_BYTES follows FPT_FRAME_CKSUM_EN (5 bytes with checksum, 4 without).
package fpt_telem_pkg;

   localparam logic [7:0] SYNC_BYTE = 8'hA5;

   localparam logic [3:0] TYPE_VETO = 4'd1;
   localparam logic [3:0] TYPE_ATT  = 4'd2;
   localparam logic [3:0] TYPE_HB   = 4'd3;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LOAD,
      ST_START,
      ST_DATA,
      ST_STOP
   } state_t;

`ifdef FPT_FRAME_CKSUM_EN
   localparam int FRAME_BYTES = 5;
`else
   localparam int FRAME_BYTES = 4;
`endif

   function automatic logic [7:0] sat_add8(input logic [7:0] a, input logic [1:0] b);
      logic [8:0] s;
      s = {1'b0, a} + {7'b0, b};
      return s[8] ? 8'hFF : s[7:0];
   endfunction

endpackage

// File: rtl/fpt_uart_byte_tx.sv
// 8N1 byte serialiser: baud counter plus START/DATA/STOP shifter, LSB first.
// done is high in the final STOP cycle so the next byte can be loaded without a gap.
module fpt_uart_byte_tx
   import fpt_telem_pkg::*;
#(
   parameter int CLKS_PER_BIT = 1233
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       load,
   input  logic [7:0] tx_byte,
   output logic       tx,
   output logic       done
);

   localparam int            CW       = $clog2(CLKS_PER_BIT);
   localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);

   state_t        state;
   logic [CW-1:0] cnt;
   logic [2:0]    bit_idx;
   logic [7:0]    shreg;
   logic          bit_end;

   assign bit_end = (cnt == CNT_LAST);
   assign done    = (state == ST_STOP) && bit_end;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= ST_IDLE;
         cnt     <= '0;
         bit_idx <= '0;
         shreg   <= '0;
         tx      <= 1'b1;
      end else if (load && (state == ST_IDLE || done)) begin
         state   <= ST_START;
         cnt     <= '0;
         bit_idx <= '0;
         shreg   <= tx_byte;
         tx      <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               cnt <= '0;
               tx  <= 1'b1;
            end
            ST_START: begin
               if (bit_end) begin
                  state <= ST_DATA;
                  cnt   <= '0;
                  tx    <= shreg[0];
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            ST_DATA: begin
               if (bit_end) begin
                  cnt <= '0;
                  if (bit_idx == 3'd7) begin
                     state <= ST_STOP;
                     tx    <= 1'b1;
                  end else begin
                     // shreg[1] is the bit that becomes shreg[0] after this shift
                     bit_idx <= bit_idx + 3'd1;
                     shreg   <= {1'b0, shreg[7:1]};
                     tx      <= shreg[1];
                  end
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            ST_STOP: begin
               if (bit_end) begin
                  state <= ST_IDLE;
                  cnt   <= '0;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: rtl/fpt_telemetry_sched.sv
// Fixed-priority telemetry scheduler (VETO > ATT > HB) framing messages onto uart_tx.
// Define FPT_FRAME_CKSUM_EN to append the B1^B2^B3 checksum byte.
module fpt_telemetry_sched
   import fpt_telem_pkg::*;
#(
   parameter int CLKS_PER_BIT = 1233,
   parameter int HB_CYCLES    = 142000000
) (
   input  logic        clk_142mhz,
   input  logic        rst_n,
   input  logic        veto_in,
   input  logic [1:0]  attention_level,
   input  logic [15:0] motor_correction,
   input  logic        tx_enable,
   output logic        uart_tx,
   output logic        busy,
   output logic        frame_done,
   output logic [7:0]  drop_cnt
);

   localparam int            TW      = $clog2(HB_CYCLES);
   localparam logic [TW-1:0] HB_LAST = TW'(HB_CYCLES - 1);
   localparam logic [2:0]    N_BYTES = 3'(FRAME_BYTES);

   state_t        state;
   logic          veto_d;
   logic [1:0]    att_d;
   logic [TW-1:0] hb_timer;
   logic          pend_veto, pend_att, pend_hb;
   logic [15:0]   snap_corr;
   logic [1:0]    snap_lvl;
   logic [3:0]    seq;
   logic [7:0]    veto_cnt;
   logic [3:0]    frm_type;
   logic [15:0]   frm_payload;
   logic [2:0]    byte_idx;

   logic          ev_veto, ev_att, ev_hb;
   logic          start_frame, grant_veto, grant_att, grant_hb;
   logic [1:0]    drops;
   logic          more_bytes, byte_load, byte_done;
   logic [7:0]    byte_data;

   function automatic logic [7:0] frame_byte(input logic [2:0]  idx,
                                             input logic [3:0]  ftype,
                                             input logic [3:0]  fseq,
                                             input logic [15:0] pay);
      case (idx)
         3'd0:    frame_byte = SYNC_BYTE;
         3'd1:    frame_byte = {ftype, fseq};
         3'd2:    frame_byte = pay[15:8];
         3'd3:    frame_byte = pay[7:0];
`ifdef FPT_FRAME_CKSUM_EN
         3'd4:    frame_byte = {ftype, fseq} ^ pay[15:8] ^ pay[7:0];
`endif
         default: frame_byte = 8'h00;
      endcase
   endfunction

   assign ev_veto = veto_in & ~veto_d;
   assign ev_att  = (attention_level != att_d);
   assign ev_hb   = (hb_timer == HB_LAST);

   assign start_frame = (state == ST_IDLE) && tx_enable && (pend_veto | pend_att | pend_hb);
   assign grant_veto  = start_frame & pend_veto;
   assign grant_att   = start_frame & ~pend_veto & pend_att;
   assign grant_hb    = start_frame & ~pend_veto & ~pend_att & pend_hb;

   // A same-edge event for the winner re-arms its flag without counting as a drop
   assign drops = {1'b0, ev_veto & pend_veto & ~grant_veto}
                + {1'b0, ev_att  & pend_att  & ~grant_att}
                + {1'b0, ev_hb   & pend_hb   & ~grant_hb};

   assign more_bytes = (byte_idx != N_BYTES);
   assign byte_load  = (state == ST_LOAD) || ((state == ST_START) && byte_done && more_bytes);
   assign byte_data  = frame_byte(byte_idx, frm_type, seq, frm_payload);

   // The top only sequences frames: after LOAD it parks in ST_START while the
   // byte transmitter walks its own START/DATA/STOP states for every byte.
   always_ff @(posedge clk_142mhz or negedge rst_n) begin
      if (!rst_n) begin
         state      <= ST_IDLE;
         busy       <= 1'b0;
         frame_done <= 1'b0;
         drop_cnt   <= '0;
         seq        <= '0;
         veto_cnt   <= '0;
         pend_veto  <= 1'b0;
         pend_att   <= 1'b0;
         pend_hb    <= 1'b0;
         hb_timer   <= '0;
         veto_d     <= 1'b0;
         att_d      <= '0;
         byte_idx   <= '0;
      end else begin
         veto_d     <= veto_in;
         att_d      <= attention_level;
         hb_timer   <= ev_hb ? '0 : hb_timer + 1'b1;
         pend_veto  <= ev_veto | (pend_veto & ~grant_veto);
         pend_att   <= ev_att  | (pend_att  & ~grant_att);
         pend_hb    <= ev_hb   | (pend_hb   & ~grant_hb);
         drop_cnt   <= sat_add8(drop_cnt, drops);
         veto_cnt   <= veto_cnt + {7'b0, ev_veto};
         frame_done <= 1'b0;

         case (state)
            ST_IDLE: begin
               if (start_frame) begin
                  state    <= ST_LOAD;
                  busy     <= 1'b1;
                  byte_idx <= '0;
               end
            end
            ST_LOAD: begin
               state    <= ST_START;
               byte_idx <= 3'd1;
            end
            ST_START: begin
               if (byte_done) begin
                  if (more_bytes) begin
                     byte_idx <= byte_idx + 3'd1;
                  end else begin
                     state      <= ST_IDLE;
                     busy       <= 1'b0;
                     frame_done <= 1'b1;
                     seq        <= seq + 4'd1;
                  end
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk_142mhz) begin
      if (ev_veto) snap_corr <= motor_correction;
      if (ev_att)  snap_lvl  <= attention_level;
      if (start_frame) begin
         frm_type    <= grant_veto ? TYPE_VETO : (grant_att ? TYPE_ATT : TYPE_HB);
         frm_payload <= grant_veto ? snap_corr : {14'b0, snap_lvl};
      end else if ((state == ST_LOAD) && (frm_type == TYPE_HB)) begin
         frm_payload <= {drop_cnt, veto_cnt};
      end
   end

   fpt_uart_byte_tx #(
      .CLKS_PER_BIT (CLKS_PER_BIT)
   ) u_byte_tx (
      .clk     (clk_142mhz),
      .rst_n   (rst_n),
      .load    (byte_load),
      .tx_byte (byte_data),
      .tx      (uart_tx),
      .done    (byte_done)
   );

endmodule

// File: tb/tb_fpt_telemetry_sched.sv
// Scoreboard bench: an event-rule model predicts frames; a line monitor decodes uart_tx.
`timescale 1ns/1ps
module tb_fpt_telemetry_sched;

   localparam int CPB = 4;
   localparam int HB  = 1000;
`ifdef FPT_FRAME_CKSUM_EN
   localparam int FB = 5;
`else
   localparam int FB = 4;
`endif
   localparam int FRAME_CYC = FB * 10 * CPB;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        veto_in = 1'b0;
   logic [1:0]  attention_level = 2'd0;
   logic [15:0] motor_correction = 16'h0;
   logic        tx_enable = 1'b0;
   logic        uart_tx, busy, frame_done;
   logic [7:0]  drop_cnt;

   always #5 clk = ~clk;

   fpt_telemetry_sched #(.CLKS_PER_BIT(CPB), .HB_CYCLES(HB)) dut (
      .clk_142mhz       (clk),
      .rst_n            (rst_n),
      .veto_in          (veto_in),
      .attention_level  (attention_level),
      .motor_correction (motor_correction),
      .tx_enable        (tx_enable),
      .uart_tx          (uart_tx),
      .busy             (busy),
      .frame_done       (frame_done),
      .drop_cnt         (drop_cnt)
   );

   typedef struct {
      logic [39:0] bytes;
      int          start_cyc;
   } frame_t;

   frame_t exp_q[$];
   int     done_q[$];
   int     tests = 0;
   int     fails = 0;
   int     cyc = 0;
   int     mon_bidx = 0;

   bit          m_vd, m_pv, m_pa, m_ph;
   logic [1:0]  m_ad, m_lvl;
   logic [15:0] m_corr;
   int          m_timer, m_drop, m_vcnt, m_seq, m_free_at;

   function automatic void check(input string name, input logic [31:0] act, input logic [31:0] req);
      tests++;
      if (act !== req) begin
         fails++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
      end
   endfunction

   // Reference model: each edge applies the event / overwrite / priority rules,
   // and the line is considered free again 2+FRAME_CYC edges after a grant.
   initial begin
      forever begin
         @(posedge clk);
         cyc++;
         if (!rst_n) begin
            m_vd = 0; m_ad = 0; m_timer = 0;
            m_pv = 0; m_pa = 0; m_ph = 0;
            m_drop = 0; m_vcnt = 0; m_seq = 0; m_free_at = 0;
         end else begin
            bit          ev_v, ev_a, ev_h;
            int          win;
            logic [15:0] pay;
            logic [7:0]  b1, b2, b3;
            frame_t      f;
            ev_v = veto_in && !m_vd;
            ev_a = (attention_level != m_ad);
            ev_h = (m_timer == HB - 1);
            win = 0;
            if (cyc >= m_free_at && tx_enable) begin
               if (m_pv) win = 1;
               else if (m_pa) win = 2;
               else if (m_ph) win = 3;
            end
            pay = (win == 1) ? m_corr : {14'b0, m_lvl};
            if (ev_v && m_pv && win != 1 && m_drop < 255) m_drop++;
            if (ev_a && m_pa && win != 2 && m_drop < 255) m_drop++;
            if (ev_h && m_ph && win != 3 && m_drop < 255) m_drop++;
            m_pv = ev_v || (m_pv && win != 1);
            m_pa = ev_a || (m_pa && win != 2);
            m_ph = ev_h || (m_ph && win != 3);
            if (ev_v) begin
               m_corr = motor_correction;
               m_vcnt = (m_vcnt + 1) % 256;
            end
            if (ev_a) m_lvl = attention_level;
            m_timer = ev_h ? 0 : m_timer + 1;
            m_vd = veto_in;
            m_ad = attention_level;
            if (win != 0) begin
               if (win == 3) pay = {8'(m_drop), 8'(m_vcnt)};
               b1 = {4'(win), 4'(m_seq)};
               b2 = pay[15:8];
               b3 = pay[7:0];
               f.bytes = {b1 ^ b2 ^ b3, b3, b2, b1, 8'hA5};
               f.start_cyc = cyc + 1;
               exp_q.push_back(f);
               done_q.push_back(cyc + 1 + FRAME_CYC);
               m_seq = (m_seq + 1) % 16;
               m_free_at = cyc + 2 + FRAME_CYC;
            end
         end
      end
   end

   // Line monitor: decodes 8N1 bytes at negedges and scores them against the queue.
   initial begin
      frame_t     cur;
      logic [7:0] rx;
      bit         aborted;
      int         k;
      cur.bytes = '0;
      cur.start_cyc = 0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            mon_bidx = 0;
         end else if (uart_tx == 1'b0) begin
            if (mon_bidx == 0) begin
               if (exp_q.size() == 0) begin
                  check("unexpected_frame", 32'd1, 32'd0);
                  cur.bytes = '0;
                  cur.start_cyc = cyc;
               end else begin
                  cur = exp_q.pop_front();
               end
               check("start_cycle", cyc, cur.start_cyc);
            end
            check("busy_in_frame", {31'b0, busy}, 32'd1);
            rx = 8'h00;
            aborted = 0;
            k = 1;
            while (k < 10 * CPB && !aborted) begin
               @(negedge clk);
               if (!rst_n) begin
                  aborted = 1;
               end else if (k % CPB == 1) begin
                  if (k / CPB == 0) check("start_bit", {31'b0, uart_tx}, 32'd0);
                  else if (k / CPB <= 8) rx[k / CPB - 1] = uart_tx;
                  else check("stop_bit", {31'b0, uart_tx}, 32'd1);
               end
               k++;
            end
            if (aborted) begin
               mon_bidx = 0;
            end else begin
               check($sformatf("frame_byte%0d", mon_bidx), {24'b0, rx}, {24'b0, cur.bytes[8*mon_bidx +: 8]});
               mon_bidx = (mon_bidx + 1 == FB) ? 0 : mon_bidx + 1;
            end
         end
      end
   end

   initial begin
      forever begin
         @(negedge clk);
         if (rst_n && frame_done) begin
            if (done_q.size() == 0) check("spurious_frame_done", 32'd1, 32'd0);
            else check("frame_done_cycle", cyc, done_q.pop_front());
         end
      end
   end

   task automatic drain();
      int n;
      n = 0;
      while (n < 5000 && !(exp_q.size() == 0 && done_q.size() == 0 && mon_bidx == 0 &&
                           cyc >= m_free_at && !(m_pv || m_pa || m_ph))) begin
         @(negedge clk);
         n++;
      end
      if (n >= 5000) check("drain_timeout", 32'd0, 32'd1);
      check("drop_cnt", {24'b0, drop_cnt}, 32'(m_drop));
   endtask

   task automatic pulse_veto(input logic [15:0] corr);
      @(negedge clk);
      veto_in = 1'b1;
      motor_correction = corr;
      @(negedge clk);
      veto_in = 1'b0;
   endtask

   initial begin
      int n;
      repeat (3) @(negedge clk);
      check("rst_uart_tx", {31'b0, uart_tx}, 32'd1);
      check("rst_busy", {31'b0, busy}, 32'd0);
      check("rst_frame_done", {31'b0, frame_done}, 32'd0);
      check("rst_drop_cnt", {24'b0, drop_cnt}, 32'd0);
      rst_n = 1'b1;
      tx_enable = 1'b1;

      pulse_veto(16'h1234);
      drain();

      @(negedge clk);
      veto_in = 1'b1;
      motor_correction = 16'($urandom);
      attention_level = 2'd2;
      @(negedge clk);
      veto_in = 1'b0;
      drain();

      @(negedge clk);
      attention_level = 2'd0;
      drain();
      tx_enable = 1'b0;
      attention_level = 2'd1;
      repeat (3) @(negedge clk);
      attention_level = 2'd3;
      repeat (3) @(negedge clk);
      check("drop_while_disabled", {24'b0, drop_cnt}, 32'(m_drop));
      check("busy_while_disabled", {31'b0, busy}, 32'd0);
      tx_enable = 1'b1;
      drain();

      repeat (1100) @(negedge clk);
      drain();

      for (int i = 0; i < 6000; i++) begin
         @(negedge clk);
         motor_correction = 16'($urandom);
         if ($urandom_range(0, 119) == 0) attention_level = 2'($urandom);
         if ($urandom_range(0, 89) == 0) veto_in = ~veto_in;
         if ($urandom_range(0, 399) == 0) tx_enable = ~tx_enable;
      end
      veto_in = 1'b0;
      tx_enable = 1'b1;
      drain();

      pulse_veto(16'($urandom));
      n = 0;
      while (!busy && n < 10) begin
         @(negedge clk);
         n++;
      end
      check("busy_before_reset", {31'b0, busy}, 32'd1);
      repeat (92) @(negedge clk);
      #1;
      rst_n = 1'b0;
      exp_q.delete();
      done_q.delete();
      #1;
      check("async_rst_uart_tx", {31'b0, uart_tx}, 32'd1);
      check("async_rst_busy", {31'b0, busy}, 32'd0);
      check("async_rst_drop_cnt", {24'b0, drop_cnt}, 32'd0);
      repeat (3) @(negedge clk);
      check("rst_hold_frame_done", {31'b0, frame_done}, 32'd0);
      check("rst_hold_uart_tx", {31'b0, uart_tx}, 32'd1);
      rst_n = 1'b1;
      pulse_veto(16'hBEEF);
      drain();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

endmodule
